controlador_hd_syscall: RTL

- Sequential executor for the two disk syscalls decoded by the control unit: REG_TO_HD (opcode 61, Sel_HD_w=1) and HD_TO_REG (opcode 62, MemToReg=2).
- Sits between the decode/register-read stage and the external HD model.
- Holds the single-cycle datapath frozen (stall) while a multi-cycle disk transaction runs.
- For reads, returns the read word plus a one-cycle register-file write enable.

---
 rtl/controlador_hd_syscall_pkg.sv | 25 ++
 rtl/controlador_hd_syscall_timeout.sv | 33 +++
 rtl/controlador_hd_syscall.sv | 134 +++++++++++++
 3 files changed

// File: rtl/controlador_hd_syscall_pkg.sv
// Shared definitions for the disk-syscall controller.
//   hd_state_t   : controller FSM state encoding
//   OP_*         : syscall opcodes handled by the control unit
//   MEMTOREG_HD  : MemToReg selector value for HD_TO_REG
// Optional feature macro used by the controller: HD_TIMEOUT_EN.
package controlador_hd_syscall_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } hd_state_t;

  localparam logic [6:0] OP_REG_TO_HD = 7'd61;
  localparam logic [6:0] OP_HD_TO_REG = 7'd62;
  localparam logic [6:0] OP_HALT      = 7'd63;

  localparam logic [1:0] MEMTOREG_HD  = 2'd2;

  function automatic logic is_hd_syscall(input logic [6:0] opcode);
    return (opcode == OP_REG_TO_HD) || (opcode == OP_HD_TO_REG);
  endfunction

endpackage

// File: rtl/controlador_hd_syscall_timeout.sv
// contador_timeout: cycle counter used to bound the wait for hd_ack.
// Only instantiated when HD_TIMEOUT_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : clear the count (issued while the request is being raised)
//   enable     : count one cycle (asserted while waiting for ack)
//   expired    : high during the LIMIT-th enabled cycle after a load
module contador_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/controlador_hd_syscall.sv
// controlador_hd_syscall: sequential executor for REG_TO_HD / HD_TO_REG.
// Freezes the single-cycle datapath (stall) while a disk transaction runs
// and returns read data with a one-cycle register-file write enable.
// Optional feature: define HD_TIMEOUT_EN to bound the wait for hd_ack by
// TIMEOUT cycles (sets sticky err, reads return all ones).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   sel_hd_w, sel_hd_r  : decoded disk write / read syscall
//   halt                : blocks acceptance of new requests
//   addr_in, wdata_in   : disk address (rs1) and write data (rs2)
//   stall               : freeze PC / suppress regWrite
//   rdata, wb_en        : read word and its one-cycle write-back pulse
//   hd_req, hd_we       : request level and direction towards the HD
//   hd_addr, hd_wdata   : latched address and write data
//   hd_ack, hd_rdata    : HD completion strobe and read data
//   op_count            : completed transactions (wraps)
//   err                 : sticky timeout flag
module controlador_hd_syscall #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_hd_w,
  input  logic              sel_hd_r,
  input  logic              halt,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              wb_en,
  output logic              hd_req,
  output logic              hd_we,
  output logic [ADDR_W-1:0] hd_addr,
  output logic [DATA_W-1:0] hd_wdata,
  input  logic              hd_ack,
  input  logic [DATA_W-1:0] hd_rdata,
  output logic [15:0]       op_count,
  output logic              err
);

  import controlador_hd_syscall_pkg::*;

  hd_state_t state;
  logic      start;
  logic      stall_q;
  logic      to_expired;

  assign start = (state == IDLE) && (sel_hd_w || sel_hd_r) && !halt;

  // The accept cycle must already hold the PC, so stall combines the
  // registered busy flag with the combinational accept condition.
  assign stall = start || stall_q;

`ifdef HD_TIMEOUT_EN
  logic err_q;

  contador_timeout #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == REQ),
    .enable (state == WAIT),
    .expired(to_expired)
  );

  assign err = err_q;
`else
  assign to_expired = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      stall_q  <= 1'b0;
      wb_en    <= 1'b0;
      hd_req   <= 1'b0;
      hd_we    <= 1'b0;
      hd_addr  <= '0;
      hd_wdata <= '0;
      rdata    <= '0;
      op_count <= '0;
`ifdef HD_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      wb_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            hd_addr  <= addr_in;
            hd_wdata <= wdata_in;
            hd_we    <= sel_hd_w;
            hd_req   <= 1'b1;
            stall_q  <= 1'b1;
            state    <= REQ;
          end
        end
        // An ack coinciding with the rising request is deliberately ignored.
        REQ: state <= WAIT;
        WAIT: begin
          if (hd_ack) begin
            if (!hd_we) begin
              rdata <= hd_rdata;
              wb_en <= 1'b1;
            end
            hd_req   <= 1'b0;
            stall_q  <= 1'b0;
            op_count <= op_count + 16'd1;
            state    <= DONE;
          end else if (to_expired) begin
            if (!hd_we) begin
              rdata <= '1;
              wb_en <= 1'b1;
            end
            hd_req  <= 1'b0;
            stall_q <= 1'b0;
`ifdef HD_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
            state   <= DONE;
          end
        end
        // Requests seen here belong to the finishing instruction.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
